// File: rtl/mac_vector_driver_if.sv
// rtl/mac_vector_driver_if.sv - stream, MAC-side and result signals of mac_vector_driver
interface mac_vector_driver_if #(
  parameter int WIDTH     = 10,
  parameter int OUT_WIDTH = 20
);
  // upstream operand-pair stream
  logic                        s_valid;
  logic                        s_ready;
  logic signed [WIDTH-1:0]     s_a;
  logic signed [WIDTH-1:0]     s_b;
  // MAC input side (driven by the driver)
  logic                        mac_clr;
  logic                        mac_valid;
  logic signed [WIDTH-1:0]     mac_a;
  logic signed [WIDTH-1:0]     mac_b;
  // MAC output side (observed by the driver)
  logic                        mac_valid_out;
  logic signed [OUT_WIDTH-1:0] mac_f;
  // downstream result stream
  logic                        m_valid;
  logic                        m_ready;
  logic signed [OUT_WIDTH-1:0] m_data;

  // the driver itself
  modport slave (
    input  s_valid, s_a, s_b, mac_valid_out, mac_f, m_ready,
    output s_ready, mac_clr, mac_valid, mac_a, mac_b, m_valid, m_data
  );

  // the environment around the driver (source, MAC, sink)
  modport master (
    output s_valid, s_a, s_b, mac_valid_out, mac_f, m_ready,
    input  s_ready, mac_clr, mac_valid, mac_a, mac_b, m_valid, m_data
  );
endinterface

// File: rtl/mac_vector_driver.sv
// rtl/mac_vector_driver.sv - buffers a vector of operand pairs, sequences it through a pipelined MAC, returns the dot product
module mac_vector_driver #(
  parameter int WIDTH     = 10,
  parameter int OUT_WIDTH = 20,
  parameter int LENGTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  mac_vector_driver_if.slave bus
);

  // counters must be able to hold LENGTH itself; buffer index only needs 0..LENGTH-1
  localparam int CW = $clog2(LENGTH + 1);
  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0]               wr_cnt;
  logic [CW-1:0]               rd_cnt;
  logic [CW-1:0]               vo_cnt;
  logic signed [OUT_WIDTH-1:0] result;

  logic signed [WIDTH-1:0]     buf_a [LENGTH];
  logic signed [WIDTH-1:0]     buf_b [LENGTH];

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = wr_cnt[IW-1:0];
  assign rd_idx = rd_cnt[IW-1:0];

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // operand buffer: written only in LOAD, where s_ready is high so every s_valid is a beat
  always_ff @(posedge clk) begin
    if (!reset && state == ST_LOAD && bus.s_valid) begin
      buf_a[wr_idx] <= bus.s_a;
      buf_b[wr_idx] <= bus.s_b;
    end
  end

  // load, issue and MAC-result counters plus the captured dot product
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      vo_cnt <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.s_valid) begin
            wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
          end
        end
        ST_CLEAR: begin
          vo_cnt <= '0;
        end
        ST_ISSUE: begin
          rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
          // a very short MAC pipeline may already answer while we are still issuing
          if (bus.mac_valid_out) begin
            vo_cnt <= vo_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (bus.mac_valid_out) begin
            vo_cnt <= vo_cnt + 1'b1;
            // the final pulse carries the complete accumulation
            if (vo_cnt == LAST) begin
              result <= bus.mac_f;
            end
          end
        end
        default: begin
          // OUTPUT holds everything; stray MAC pulses here are ignored
        end
      endcase
    end
  end

  // next-state decode and register-derived outputs, forced low while reset is asserted
  always_comb begin
    next_state    = state;
    bus.s_ready   = 1'b0;
    bus.mac_clr   = 1'b0;
    bus.mac_valid = 1'b0;
    bus.mac_a     = '0;
    bus.mac_b     = '0;
    bus.m_valid   = 1'b0;
    bus.m_data    = '0;

    case (state)
      ST_LOAD: begin
        if (bus.s_valid && wr_cnt == LAST) begin
          next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (rd_cnt == LAST) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.mac_valid_out && vo_cnt == LAST) begin
          next_state = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (bus.m_ready) begin
          next_state = ST_LOAD;
        end
      end
      default: begin
        next_state = ST_LOAD;
      end
    endcase

    if (!reset) begin
      case (state)
        ST_LOAD: begin
          bus.s_ready = 1'b1;
        end
        ST_CLEAR: begin
          bus.mac_clr = 1'b1;
        end
        ST_ISSUE: begin
          bus.mac_valid = 1'b1;
          bus.mac_a     = buf_a[rd_idx];
          bus.mac_b     = buf_b[rd_idx];
        end
        ST_OUTPUT: begin
          bus.m_valid = 1'b1;
          bus.m_data  = result;
        end
        default: begin
          // DRAIN drives nothing
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_vector_driver.sv
// tb/tb_mac_vector_driver.sv - scoreboard bench for mac_vector_driver with a behavioural pipelined MAC
module tb_mac_vector_driver;
  localparam int W   = 10;
  localparam int OW  = 20;
  localparam int L   = 4;
  localparam int LAT = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_vector_driver_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus ();
  mac_vector_driver_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus1 ();

  mac_vector_driver #(.WIDTH(W), .OUT_WIDTH(OW), .LENGTH(L)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mac_vector_driver #(.WIDTH(W), .OUT_WIDTH(OW), .LENGTH(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [OW-1:0] sb  [$];
  logic signed [OW-1:0] sb1 [$];
  logic inj;

  // behavioural MAC for dut: clear on reset or mac_clr, LAT-cycle valid/result pipeline
  logic signed [OW-1:0] acc0;
  logic [LAT-1:0]       vp0;
  logic signed [OW-1:0] fp0 [LAT];
  always @(posedge clk) begin
    int s;
    s = int'(acc0) + (bus.mac_valid ? int'(bus.mac_a) * int'(bus.mac_b) : 0);
    if (reset || bus.mac_clr) begin
      acc0 <= '0;
      vp0  <= '0;
    end else begin
      acc0 <= s[OW-1:0];
      vp0  <= {vp0[LAT-2:0], bus.mac_valid};
    end
    fp0[0] <= s[OW-1:0];
    for (int i = 1; i < LAT; i++) fp0[i] <= fp0[i-1];
  end
  assign bus.mac_valid_out = vp0[LAT-1] | inj;
  assign bus.mac_f         = fp0[LAT-1];

  // same MAC model for the LENGTH=1 instance
  logic signed [OW-1:0] acc1;
  logic [LAT-1:0]       vp1;
  logic signed [OW-1:0] fp1 [LAT];
  always @(posedge clk) begin
    int s;
    s = int'(acc1) + (bus1.mac_valid ? int'(bus1.mac_a) * int'(bus1.mac_b) : 0);
    if (reset || bus1.mac_clr) begin
      acc1 <= '0;
      vp1  <= '0;
    end else begin
      acc1 <= s[OW-1:0];
      vp1  <= {vp1[LAT-2:0], bus1.mac_valid};
    end
    fp1[0] <= s[OW-1:0];
    for (int i = 1; i < LAT; i++) fp1[i] <= fp1[i-1];
  end
  assign bus1.mac_valid_out = vp1[LAT-1];
  assign bus1.mac_f         = fp1[LAT-1];

  // drive one vector into dut; expected dot product goes to the scoreboard when push is set
  task automatic send_vec(input int a[4], input int b[4], input bit gapped, input bit push,
                          output bit ok);
    int sum;
    bit acc;
    logic signed [OW-1:0] e;
    sum = 0;
    ok  = 1'b1;
    for (int i = 0; i < L; i++) sum += a[i] * b[i];
    e = sum[OW-1:0];
    if (push) sb.push_back(e);
    for (int i = 0; i < L; i++) begin
      bus.s_valid = 1'b1;
      bus.s_a     = a[i][W-1:0];
      bus.s_b     = b[i][W-1:0];
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = bus.s_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) ok = 1'b0;
      if (gapped && i != L - 1) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  // wait (bounded) until dut presents m_valid; returns at the negedge of that cycle
  task automatic wait_mvalid(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.mac_valid !== 1'b0 || bus.mac_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got s_ready=%b m_valid=%b mac_valid=%b mac_clr=%b want all 0",
               bus.s_ready, bus.m_valid, bus.mac_valid, bus.mac_clr);
    end
    n_cmp++;
    if (bus.m_data !== '0 || bus.mac_a !== '0 || bus.mac_b !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got m_data=%0d mac_a=%0d mac_b=%0d want 0", bus.m_data, bus.mac_a, bus.mac_b);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.s_ready !== 1'b1 || bus1.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", bus.s_ready, bus1.s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int va[4] = '{1, 2, 3, 4};
    int vb[4] = '{5, 6, 7, 8};
    bit ok;
    logic signed [OW-1:0] e;
    logic signed [W-1:0] ea, eb;
    send_vec(va, vb, 1'b0, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_accept: got timeout want 4 beats accepted"); end
    @(negedge clk);
    n_cmp++;
    if (bus.mac_clr !== 1'b1 || bus.mac_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_clr: got mac_clr=%b mac_valid=%b s_ready=%b want 1 0 0",
               bus.mac_clr, bus.mac_valid, bus.s_ready);
    end
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      ea = va[i][W-1:0];
      eb = vb[i][W-1:0];
      n_cmp++;
      if (bus.mac_valid !== 1'b1 || bus.mac_a !== ea || bus.mac_b !== eb) begin
        n_bad++;
        $display("FAIL basic_issue%0d: got v=%b a=%0d b=%0d want v=1 a=%0d b=%0d",
                 i, bus.mac_valid, bus.mac_a, bus.mac_b, ea, eb);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.mac_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_issue_end: got mac_valid=%b want 0", bus.mac_valid);
    end
    wait_mvalid(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_result: got no m_valid want %0d", e);
    end else if (bus.m_data !== e) begin
      n_bad++;
      $display("FAIL basic_result: got %0d want %0d", bus.m_data, e);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_return: got s_ready=%b m_valid=%b want 1 0", bus.s_ready, bus.m_valid);
    end
  endtask

  task automatic test_signed();
    int va[4] = '{-512, -512, 511, 0};
    int vb[4] = '{-512, 511, -512, 7};
    bit ok;
    logic signed [OW-1:0] e;
    @(posedge clk);
    #1;
    send_vec(va, vb, 1'b0, 1'b1, ok);
    wait_mvalid(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || bus.m_data !== e) begin
      n_bad++;
      $display("FAIL signed_result: got valid=%b data=%0d want %0d", ok, bus.m_data, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int va[4] = '{-3, 7, 100, -200};
    int vb[4] = '{9, -11, 50, 3};
    bit ok;
    bit bad;
    logic signed [OW-1:0] e;
    bus.m_ready = 1'b0;
    send_vec(va, vb, 1'b1, 1'b1, ok);
    wait_mvalid(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || bus.m_data !== e) begin
      n_bad++;
      $display("FAIL bp_result: got valid=%b data=%0d want %0d", ok, bus.m_data, e);
    end
    bad = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_data !== e || bus.s_ready !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL bp_hold: got m_valid=%b m_data=%0d s_ready=%b want 1 %0d 0",
               bus.m_valid, bus.m_data, bus.s_ready, e);
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got m_valid=%b s_ready=%b want 0 1", bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_reset_mid();
    int xa[4] = '{9, 9, 9, 9};
    int va[4] = '{2, 2, 2, 2};
    int vb[4] = '{3, 3, 3, 3};
    bit ok;
    bit seen;
    logic signed [OW-1:0] e;
    @(posedge clk);
    #1;
    send_vec(xa, xa, 1'b0, 1'b0, ok);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.mac_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_during: got mac_valid=%b s_ready=%b want 0 0", bus.mac_valid, bus.s_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mac_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.mac_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: got mac_valid=%b s_ready=%b m_valid=%b mac_clr=%b want 0 1 0 0",
               bus.mac_valid, bus.s_ready, bus.m_valid, bus.mac_clr);
    end
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.m_valid || bus.mac_valid || bus.mac_clr) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_mid_idle: got activity after reset want none");
    end
    @(posedge clk);
    #1;
    send_vec(va, vb, 1'b0, 1'b1, ok);
    wait_mvalid(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || bus.m_data !== e) begin
      n_bad++;
      $display("FAIL rst_mid_next: got valid=%b data=%0d want %0d", ok, bus.m_data, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_spurious();
    int va[4] = '{1, 2, 3, 4};
    int vb[4] = '{5, 6, 7, 8};
    bit ok;
    logic signed [OW-1:0] e;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_load: got s_ready=%b m_valid=%b want 1 0", bus.s_ready, bus.m_valid);
    end
    @(posedge clk);
    #1;
    send_vec(va, vb, 1'b0, 1'b1, ok);
    wait_mvalid(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || bus.m_data !== e) begin
      n_bad++;
      $display("FAIL spur_result: got valid=%b data=%0d want %0d", ok, bus.m_data, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int pa[2] = '{3, -1};
    int pb[2] = '{-4, -1};
    int sent;
    int got;
    bit rdy;
    logic signed [OW-1:0] e;
    for (int i = 0; i < 2; i++) begin
      int p;
      p = pa[i] * pb[i];
      e = p[OW-1:0];
      sb1.push_back(e);
    end
    sent = 0;
    got  = 0;
    bus1.s_valid = 1'b1;
    bus1.s_a     = pa[0][W-1:0];
    bus1.s_b     = pb[0][W-1:0];
    for (int t = 0; t < 300 && got < 2; t++) begin
      @(negedge clk);
      if (bus1.m_valid) begin
        e = sb1.pop_front();
        n_cmp++;
        if (bus1.m_data !== e) begin
          n_bad++;
          $display("FAIL b2b_result%0d: got %0d want %0d", got, bus1.m_data, e);
        end
        got++;
      end
      rdy = bus1.s_ready;
      @(posedge clk);
      #1;
      if (rdy && bus1.s_valid) begin
        sent++;
        if (sent < 2) begin
          bus1.s_a = pa[sent][W-1:0];
          bus1.s_b = pb[sent][W-1:0];
        end else begin
          bus1.s_valid = 1'b0;
        end
      end
    end
    n_cmp++;
    if (got != 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results want 2", got);
    end
    bus1.s_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    inj          = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_a      = '0;
    bus.s_b      = '0;
    bus.m_ready  = 1'b1;
    bus1.s_valid = 1'b0;
    bus1.s_a     = '0;
    bus1.s_b     = '0;
    bus1.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
